spi_regfile_slave: RTL and testbench

//  Parametrised SPI slave bridging a host SPI master to an on-chip register file of NUM_REGS words of WORD_W bits.

---
 rtl/spi_regfile_slave_pkg.sv | 24 ++
 rtl/spi_regfile_slave_if.sv | 27 ++
 rtl/spi_regfile_slave_sync_edge.sv | 24 ++
 rtl/spi_regfile_slave.sv | 145 ++++++++++++++
 tb/tb_spi_regfile_slave.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_regfile_slave_pkg.sv
// Opcode/state encodings and an address-window helper shared by the SPI
// register-file slave.
package spi_regfile_slave_pkg;

   typedef enum logic [1:0] {
      OP_NOP = 2'b00,
      OP_WR  = 2'b01,
      OP_RD  = 2'b10,
      OP_CLR = 2'b11
   } op_t;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_CMD  = 3'd1;
   localparam logic [2:0] ST_RD   = 3'd2;
   localparam logic [2:0] ST_WR   = 3'd3;
   localparam logic [2:0] ST_DROP = 3'd4;

   // True when lo <= a < hi.
   function automatic logic in_window(input logic [31:0] a, input logic [31:0] lo,
                                      input logic [31:0] hi);
      return (a >= lo) && (a < hi);
   endfunction

endpackage

// File: rtl/spi_regfile_slave_if.sv
// SPI pins plus register-file request/response signals of the slave bridge.
interface spi_regfile_slave_if #(
   parameter int WORD_W = 16,
   parameter int ADDR_W = 10
);
   logic              SPI_CLK;
   logic              SSEL;
   logic              MOSI;
   logic              MISO;
   logic              REG_RD_EN;
   logic [ADDR_W-1:0] REG_RD_ADDR;
   logic [WORD_W-1:0] REG_RD_DATA;
   logic              REG_WR_EN;
   logic [ADDR_W-1:0] REG_WR_ADDR;
   logic [WORD_W-1:0] REG_WR_DATA;
   logic              ERR;

   modport slave (
      input  SPI_CLK, SSEL, MOSI, REG_RD_DATA,
      output MISO, REG_RD_EN, REG_RD_ADDR, REG_WR_EN, REG_WR_ADDR, REG_WR_DATA, ERR
   );

   modport master (
      output SPI_CLK, SSEL, MOSI, REG_RD_DATA,
      input  MISO, REG_RD_EN, REG_RD_ADDR, REG_WR_EN, REG_WR_ADDR, REG_WR_DATA, ERR
   );
endinterface

// File: rtl/spi_regfile_slave_sync_edge.sv
// N-stage synchroniser; level and edges are taken from its two oldest stages,
// so any action on an edge lands exactly STAGES clocks after the pin changed.
module spi_regfile_slave_sync_edge #(
   parameter int STAGES = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] chain;

   // Reset to 0 so a slave select already low at reset never looks like a new frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) chain <= '0;
      else     chain <= {chain[STAGES-2:0], raw};
   end

   assign level = chain[STAGES-2];
   assign rise  = chain[STAGES-2] & ~chain[STAGES-1];
   assign fall  = ~chain[STAGES-2] & chain[STAGES-1];
endmodule

// File: rtl/spi_regfile_slave.sv
// SPI slave bridging a host master to a register file: burst read/write with
// auto-increment, write-protected low region and sticky range/protection error.
module spi_regfile_slave
   import spi_regfile_slave_pkg::*;
#(
   parameter int                WORD_W      = 16,
   parameter int                ADDR_W      = 10,
   parameter int                NUM_REGS    = 43,
   parameter int                WR_BASE     = 24,
   parameter int                SYNC_STAGES = 3,
   parameter logic [WORD_W-1:0] IDLE_WORD   = 16'h0003
) (
   input logic                 SYS_CLK,
   input logic                 SYS_RST,
   spi_regfile_slave_if.slave  bus
);
   localparam int CNT_W = $clog2(WORD_W);

   logic              sck_level_unused, sck_rise, sck_fall;
   logic              ssel_level, ssel_rise, ssel_fall;
   logic              mosi_level, mosi_rise_unused, mosi_fall_unused;
   logic [CNT_W-1:0]  bit_cnt;
   logic [WORD_W-2:0] rx_shift;
   logic [WORD_W-1:0] rx_word, tx_shift, tx_hold, tx_src, wr_word;
   logic [ADDR_W-1:0] addr;
   logic [2:0]        state;
   logic              last_bit, word_done, rd_req, rd_cap, rd_bad, wr_req;
   logic              addr_readable, addr_writable, err_set, err_clr;
   op_t               cmd_op;

   spi_regfile_slave_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
      .clk(SYS_CLK), .rst(SYS_RST), .raw(bus.SPI_CLK),
      .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall));
   spi_regfile_slave_sync_edge #(.STAGES(SYNC_STAGES)) u_ssel (
      .clk(SYS_CLK), .rst(SYS_RST), .raw(bus.SSEL),
      .level(ssel_level), .rise(ssel_rise), .fall(ssel_fall));
   spi_regfile_slave_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
      .clk(SYS_CLK), .rst(SYS_RST), .raw(bus.MOSI),
      .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

   assign rx_word       = {rx_shift, mosi_level};
   assign last_bit      = (bit_cnt == CNT_W'(WORD_W - 1));
   assign word_done     = sck_fall && !ssel_level && last_bit;
   assign cmd_op        = op_t'(rx_word[WORD_W-1 -: 2]);
   assign addr_readable = in_window(32'(addr), 32'd0, 32'(NUM_REGS));
   assign addr_writable = in_window(32'(addr), 32'(WR_BASE), 32'(NUM_REGS));
   assign tx_src        = (state == ST_CMD || state == ST_RD || state == ST_WR) ? tx_hold : '0;
   assign err_set       = (rd_cap && rd_bad) || (wr_req && !addr_writable);
   assign err_clr       = (state == ST_CMD) && word_done && !ssel_rise && (cmd_op == OP_CLR);
   assign bus.MISO      = tx_shift[WORD_W-1];

   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         bit_cnt  <= '0;
         rx_shift <= '0;
         tx_shift <= '0;
      end else if (ssel_level) begin
         bit_cnt <= '0;
      end else begin
         if (sck_fall) begin
            rx_shift <= rx_word[WORD_W-2:0];
            bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
         end
         if (sck_rise)
            tx_shift <= (bit_cnt == '0) ? tx_src : {tx_shift[WORD_W-2:0], 1'b0};
      end
   end

   // Read path: request one cycle after word_done, data returns a cycle after
   // the strobe and lands in tx_hold well before the next word's first SCK rise.
   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         state           <= ST_IDLE;
         tx_hold         <= IDLE_WORD;
         addr            <= '0;
         rd_req          <= 1'b0;
         rd_cap          <= 1'b0;
         rd_bad          <= 1'b0;
         wr_req          <= 1'b0;
         wr_word         <= '0;
         bus.REG_RD_EN   <= 1'b0;
         bus.REG_RD_ADDR <= '0;
         bus.REG_WR_EN   <= 1'b0;
         bus.REG_WR_ADDR <= '0;
         bus.REG_WR_DATA <= '0;
         bus.ERR         <= 1'b0;
      end else begin
         bus.REG_RD_EN <= 1'b0;
         bus.REG_WR_EN <= 1'b0;
         rd_req        <= 1'b0;
         wr_req        <= 1'b0;
         rd_cap        <= bus.REG_RD_EN;
         if (rd_req) begin
            bus.REG_RD_EN   <= 1'b1;
            bus.REG_RD_ADDR <= addr;
            rd_bad          <= !addr_readable;
            addr            <= addr + 1'b1;
         end
         if (rd_cap) tx_hold <= rd_bad ? '0 : bus.REG_RD_DATA;
         if (wr_req) begin
            if (addr_writable) begin
               bus.REG_WR_EN   <= 1'b1;
               bus.REG_WR_ADDR <= addr;
               bus.REG_WR_DATA <= wr_word;
            end
            addr <= addr + 1'b1;
         end
         if (err_set)      bus.ERR <= 1'b1;
         else if (err_clr) bus.ERR <= 1'b0;

         // A slave-select rise abandons whatever word was in flight.
         if (ssel_rise) state <= ST_IDLE;
         else begin
            case (state)
               ST_IDLE: if (ssel_fall) begin
                  state   <= ST_CMD;
                  tx_hold <= IDLE_WORD;
               end
               ST_CMD: if (word_done) begin
                  case (cmd_op)
                     OP_RD: begin
                        addr   <= rx_word[ADDR_W-1:0];
                        rd_req <= 1'b1;
                        state  <= ST_RD;
                     end
                     OP_WR: begin
                        addr    <= rx_word[ADDR_W-1:0];
                        tx_hold <= rx_word;
                        state   <= ST_WR;
                     end
                     default: state <= ST_DROP;
                  endcase
               end
               ST_RD: if (word_done) rd_req <= 1'b1;
               ST_WR: if (word_done) begin
                  wr_req  <= 1'b1;
                  wr_word <= rx_word;
                  tx_hold <= rx_word;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_spi_regfile_slave.sv
// Self-checking bench: directed frames plus random frames checked against a
// frame-level model of opcode, address window and sticky error rules.
module tb_spi_regfile_slave;
   logic SYS_CLK = 1'b0;
   logic SYS_RST;
   int   checks = 0;
   int   errors = 0;
   int   overlap = 0;
   int   model_err = 0;

   int          rd_log[$];
   int          wr_addr_log[$];
   logic [15:0] wr_data_log[$];
   logic [15:0] frame_q[$];

   spi_regfile_slave_if #(.WORD_W(16), .ADDR_W(10)) bus ();

   spi_regfile_slave dut (
      .SYS_CLK(SYS_CLK),
      .SYS_RST(SYS_RST),
      .bus    (bus)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   // Register-file stand-in: word at address a reads as a*0x0101, one clock after the strobe.
   always @(posedge SYS_CLK)
      if (bus.REG_RD_EN) bus.REG_RD_DATA <= 16'({6'd0, bus.REG_RD_ADDR} * 16'h0101);

   always @(negedge SYS_CLK) begin
      if (bus.REG_RD_EN) rd_log.push_back(int'(bus.REG_RD_ADDR));
      if (bus.REG_WR_EN) begin
         wr_addr_log.push_back(int'(bus.REG_WR_ADDR));
         wr_data_log.push_back(bus.REG_WR_DATA);
      end
      if (bus.REG_RD_EN && bus.REG_WR_EN) overlap++;
   end

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Shifts n bits MSB first: MOSI changes on SCK rise, MISO is sampled just before the fall.
   task automatic apply_stimulus(input logic [31:0] tx, input int n, output logic [31:0] rx);
      rx = '0;
      for (int i = n - 1; i >= 0; i--) begin
         bus.MOSI    = tx[i];
         bus.SPI_CLK = 1'b1;
         repeat (5) @(negedge SYS_CLK);
         rx[i]       = bus.MISO;
         bus.SPI_CLK = 1'b0;
         repeat (5) @(negedge SYS_CLK);
      end
   endtask

   task automatic load_frame(input int n, input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
      logic [15:0] w[4];
      w = '{w0, w1, w2, w3};
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back(w[i]);
   endtask

   task automatic run_frame(input string tag, input int extra_bits);
      logic [15:0] exp_miso[$];
      int          exp_rd[$];
      int          exp_wa[$];
      logic [15:0] exp_wd[$];
      logic [15:0] cmd;
      logic [31:0] rx;
      int          n, a, ad, rd_base, wr_base;
      n       = frame_q.size();
      cmd     = frame_q[0];
      a       = int'(cmd[9:0]);
      rd_base = rd_log.size();
      wr_base = wr_addr_log.size();

      exp_miso.push_back(16'h0003);
      for (int k = 1; k < n; k++) begin
         ad = (a + k - 1) % 1024;
         case (cmd[15:14])
            2'b10:   exp_miso.push_back(ad < 43 ? 16'(ad * 257) : 16'h0000);
            2'b01:   exp_miso.push_back(k == 1 ? cmd : frame_q[k-1]);
            default: exp_miso.push_back(16'h0000);
         endcase
      end
      if (cmd[15:14] == 2'b10) begin
         for (int k = 0; k < n; k++) begin
            ad = (a + k) % 1024;
            exp_rd.push_back(ad);
            if (ad >= 43) model_err = 1;
         end
      end else if (cmd[15:14] == 2'b01) begin
         for (int k = 1; k < n; k++) begin
            ad = (a + k - 1) % 1024;
            if (ad >= 24 && ad < 43) begin
               exp_wa.push_back(ad);
               exp_wd.push_back(frame_q[k]);
            end else model_err = 1;
         end
      end else if (cmd[15:14] == 2'b11) model_err = 0;

      bus.SSEL = 1'b0;
      repeat (10) @(negedge SYS_CLK);
      for (int k = 0; k < n; k++) begin
         apply_stimulus({16'h0, frame_q[k]}, 16, rx);
         check_output($sformatf("%s miso%0d", tag, k), rx, {16'h0, exp_miso[k]});
      end
      if (extra_bits > 0) apply_stimulus($urandom, extra_bits, rx);
      repeat (10) @(negedge SYS_CLK);
      bus.SSEL = 1'b1;
      repeat (12) @(negedge SYS_CLK);

      check_output({tag, " rd_count"}, rd_log.size() - rd_base, exp_rd.size());
      for (int i = 0; i < exp_rd.size() && rd_base + i < rd_log.size(); i++)
         check_output($sformatf("%s rd_addr%0d", tag, i), rd_log[rd_base+i], exp_rd[i]);
      check_output({tag, " wr_count"}, wr_addr_log.size() - wr_base, exp_wa.size());
      for (int i = 0; i < exp_wa.size() && wr_base + i < wr_addr_log.size(); i++) begin
         check_output($sformatf("%s wr_addr%0d", tag, i), wr_addr_log[wr_base+i], exp_wa[i]);
         check_output($sformatf("%s wr_data%0d", tag, i), wr_data_log[wr_base+i], exp_wd[i]);
      end
      check_output({tag, " err"}, bus.ERR, model_err);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, " MISO"}, bus.MISO, 0);
      check_output({tag, " RD_EN"}, bus.REG_RD_EN, 0);
      check_output({tag, " WR_EN"}, bus.REG_WR_EN, 0);
      check_output({tag, " RD_ADDR"}, bus.REG_RD_ADDR, 0);
      check_output({tag, " WR_ADDR"}, bus.REG_WR_ADDR, 0);
      check_output({tag, " WR_DATA"}, bus.REG_WR_DATA, 0);
      check_output({tag, " ERR"}, bus.ERR, 0);
   endtask

   initial begin
      logic [31:0] rx;
      int          rd_base;
      bus.SPI_CLK = 1'b0;
      bus.SSEL    = 1'b1;
      bus.MOSI    = 1'b0;
      SYS_RST     = 1'b1;
      repeat (3) @(negedge SYS_CLK);
      check_reset_outputs("por");
      SYS_RST = 1'b0;
      repeat (10) @(negedge SYS_CLK);

      load_frame(4, 16'h8005, 16'h1111, 16'h2222, 16'h3333);
      run_frame("burst_rd", 0);
      load_frame(3, 16'h4018, 16'h1234, 16'hBEEF, 16'h0);
      run_frame("burst_wr", 0);
      load_frame(2, 16'h4002, 16'hFFFF, 16'h0, 16'h0);
      run_frame("prot_wr", 0);
      load_frame(1, 16'hC000, 16'h0, 16'h0, 16'h0);
      run_frame("clr", 0);
      load_frame(3, 16'h802A, 16'h0, 16'h0, 16'h0);
      run_frame("range_edge", 0);
      load_frame(1, 16'h4020, 16'h0, 16'h0, 16'h0);
      run_frame("abort", 9);
      load_frame(2, 16'h8000, 16'h5A5A, 16'h0, 16'h0);
      run_frame("after_abort", 0);

      // Reset in the middle of a burst read; the remainder of the frame must be dropped.
      bus.SSEL = 1'b0;
      repeat (10) @(negedge SYS_CLK);
      apply_stimulus(32'h8005, 16, rx);
      check_output("mid_rst miso0", rx, 32'h0003);
      apply_stimulus(32'h0, 16, rx);
      check_output("mid_rst miso1", rx, 32'h0505);
      apply_stimulus(32'h0, 5, rx);
      SYS_RST = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      @(negedge SYS_CLK);
      SYS_RST   = 1'b0;
      model_err = 0;
      rd_base   = rd_log.size();
      apply_stimulus($urandom, 27, rx);
      check_output("mid_rst drop miso", rx, 32'h0);
      repeat (10) @(negedge SYS_CLK);
      bus.SSEL = 1'b1;
      repeat (12) @(negedge SYS_CLK);
      check_output("mid_rst no_rd", rd_log.size() - rd_base, 0);
      load_frame(2, 16'h8005, 16'h0, 16'h0, 16'h0);
      run_frame("post_rst", 0);

      for (int f = 0; f < 24; f++) begin
         logic [1:0] op;
         int         a, nd, xb;
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       a = $urandom_range(0, 50);
            1:       a = $urandom_range(18, 30);
            2:       a = $urandom_range(38, 46);
            default: a = $urandom_range(1020, 1023);
         endcase
         nd = $urandom_range(0, 4);
         xb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
         frame_q.delete();
         frame_q.push_back({op, 4'($urandom), 10'(a)});
         for (int k = 0; k < nd; k++) frame_q.push_back(16'($urandom));
         run_frame($sformatf("rnd%0d", f), xb);
      end

      check_output("rd_wr_overlap", overlap, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
